// File: rtl/ram_bus_master.sv
// RAM bus initiator: turns req/ack transactions into CS/R_W/Addr/Data cycles.
// Optional RAM_BUS_MASTER_VERIFY_EN reads back and compares every write.
module ram_bus_master #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  Rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  verify_err,
  inout  wire  [DATA_WIDTH-1:0] Data,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic                  R_W,
  output logic                  CS
);

  localparam int RL = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int CW = (RL > 1) ? $clog2(RL) : 1;
  localparam logic [CW-1:0] LAST = CW'(RL - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    TURN,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive;

  // Drive enable is a register, so it can only be high in WRITE.
  assign Data = drive ? wdata_q : 'z;

`ifdef RAM_BUS_MASTER_VERIFY_EN
  logic chk;
  logic mis;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wdata_q <= '0;
      drive   <= 1'b0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      Addr    <= '0;
      R_W     <= 1'b1;
      CS      <= 1'b0;
`ifdef RAM_BUS_MASTER_VERIFY_EN
      chk        <= 1'b0;
      mis        <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            Addr    <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            CS      <= 1'b1;
            cnt     <= '0;
`ifdef RAM_BUS_MASTER_VERIFY_EN
            chk        <= we;
            mis        <= 1'b0;
            verify_err <= 1'b0;
`endif
            if (we) begin
              state <= WRITE;
              R_W   <= 1'b0;
              drive <= 1'b1;
            end else begin
              state <= READ;
              R_W   <= 1'b1;
            end
          end
        end
        WRITE: begin
          drive <= 1'b0;
          R_W   <= 1'b1;
`ifdef RAM_BUS_MASTER_VERIFY_EN
          state <= READ;
          cnt   <= '0;
`else
          state <= DONE;
          CS    <= 1'b0;
          ack   <= 1'b1;
`endif
        end
        READ: begin
          if (cnt == LAST) begin
            rdata <= Data;
            CS    <= 1'b0;
            state <= TURN;
`ifdef RAM_BUS_MASTER_VERIFY_EN
            mis   <= chk && (Data != wdata_q);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TURN: begin
          state <= DONE;
          ack   <= 1'b1;
`ifdef RAM_BUS_MASTER_VERIFY_EN
          verify_err <= mis;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master: two instances (READ_LATENCY 1 and 3)
// each on its own modelled RAM bus with a keeper pattern when undriven.
`timescale 1ns/1ps
module tb_ram_bus_master;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [DW-1:0] KEEP  = 32'h5A5A_5A5A;
  localparam logic [DW-1:0] FORCE = 32'h1234_5679;

  typedef struct {
    logic          cs;
    logic          rwchk;
    logic          drv;
    logic          ack;
    logic          err;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n [2];
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack   [2];
  logic          busy  [2];
  logic [DW-1:0] rdata [2];
  logic          verr  [2];
  logic [AW-1:0] ba    [2];
  logic          rw    [2];
  logic          cs    [2];
  wire  [DW-1:0] data_a;
  wire  [DW-1:0] data_b;
  logic [DW-1:0] bus   [2];

  always #5 clk = ~clk;

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_a (
    .CLK(clk), .Rst(rst_n[0]), .req(req[0]), .we(we[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ack(ack[0]), .busy(busy[0]),
    .rdata(rdata[0]), .verify_err(verr[0]), .Data(data_a),
    .Addr(ba[0]), .R_W(rw[0]), .CS(cs[0])
  );

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_b (
    .CLK(clk), .Rst(rst_n[1]), .req(req[1]), .we(we[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ack(ack[1]), .busy(busy[1]),
    .rdata(rdata[1]), .verify_err(verr[1]), .Data(data_b),
    .Addr(ba[1]), .R_W(rw[1]), .CS(cs[1])
  );

  // RAM model: drives read data while selected for read, a keeper value
  // whenever the master is not writing, and captures writes at the edge.
  logic [DW-1:0] mem [2][4096];
  logic          force_rb [2];
  logic [DW-1:0] ram_val  [2];
  logic          pl_en;
  int            pl_i;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  assign bus[0] = data_a;
  assign bus[1] = data_b;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ram_val[i] = KEEP;
      if (cs[i] && rw[i])
        ram_val[i] = force_rb[i] ? FORCE : mem[i][ba[i]];
    end
  end

  assign data_a = (cs[0] && !rw[0]) ? 'z : ram_val[0];
  assign data_b = (cs[1] && !rw[1]) ? 'z : ram_val[1];

  always @(posedge clk) begin
    if (pl_en) mem[pl_i][pl_a] <= pl_d;
    for (int i = 0; i < 2; i++)
      if (cs[i] && !rw[i]) mem[i][ba[i]] <= bus[i];
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t me;
  logic [DW-1:0] hold_rd  [2];
  logic          hold_err [2];
  logic [DW-1:0] last_rd  [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [DW-1:0] act,
                              logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endfunction

  // Monitor: one expected entry per busy cycle; idle cycles must be quiet.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        if (i == 0) q0.delete();
        else q1.delete();
        hold_rd[i]  = '0;
        hold_err[i] = 1'b0;
      end else if (busy[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL busy%0d: got busy=1 expected no transaction", i);
        end else begin
          if (i == 0) me = q0.pop_front();
          else me = q1.pop_front();
          chk($sformatf("cs%0d", i), DW'(cs[i]), DW'(me.cs));
          chk($sformatf("ack%0d", i), DW'(ack[i]), DW'(me.ack));
          if (me.cs) chk($sformatf("addr%0d", i), DW'(ba[i]), DW'(me.a));
          if (me.rwchk)
            chk($sformatf("r_w%0d", i), DW'(rw[i]), DW'(!me.drv));
          if (me.drv) chk($sformatf("wbus%0d", i), bus[i], me.d);
          else chk($sformatf("nodrive%0d", i), bus[i], ram_val[i]);
          chk($sformatf("verr%0d", i), DW'(verr[i]),
              DW'(me.ack ? me.err : 1'b0));
          if (me.ack) begin
            chk($sformatf("rdata%0d", i), rdata[i], me.d);
            chk($sformatf("ackcyc%0d", i), DW'(cyc), DW'(me.cyc));
            hold_rd[i]  = me.d;
            hold_err[i] = me.err;
          end
        end
      end else begin
        chk($sformatf("idle_cs%0d", i), DW'(cs[i]), '0);
        chk($sformatf("idle_rw%0d", i), DW'(rw[i]), 1);
        chk($sformatf("idle_ack%0d", i), DW'(ack[i]), '0);
        chk($sformatf("idle_bus%0d", i), bus[i], KEEP);
        chk($sformatf("idle_rdata%0d", i), rdata[i], hold_rd[i]);
        chk($sformatf("idle_verr%0d", i), DW'(verr[i]), DW'(hold_err[i]));
      end
    end
  end

  task automatic push(int i, exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected bus/handshake trace for one transaction, one entry per cycle.
  task automatic build(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] wd,
                       logic [DW-1:0] rd, logic er, output int lat);
    int   rl;
    exp_t e;
    rl = (i == 0) ? 1 : 3;
    e = '{cs: 1'b1, rwchk: 1'b1, drv: 1'b0, ack: 1'b0, err: 1'b0,
          a: a, d: '0, cyc: 0};
    if (w) begin
      e.drv = 1'b1;
      e.d   = wd;
      push(i, e);
      e.drv = 1'b0;
`ifdef RAM_BUS_MASTER_VERIFY_EN
      for (int k = 0; k < rl; k++) push(i, e);
      e.cs = 1'b0;
      push(i, e);
      lat = rl + 3;
      last_rd[i] = rd;
`else
      lat = 2;
      er  = 1'b0;
`endif
    end else begin
      for (int k = 0; k < rl; k++) push(i, e);
      e.cs = 1'b0;
      push(i, e);
      lat = rl + 2;
      last_rd[i] = rd;
    end
    e.cs    = 1'b0;
    e.rwchk = 1'b0;
    e.ack   = 1'b1;
    e.err   = er;
    e.d     = last_rd[i];
    e.cyc   = cyc + lat;
    push(i, e);
  endtask

  task automatic issue(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] wd,
                       logic [DW-1:0] rd, logic er, bit hold);
    int lat;
    @(negedge clk);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = wd;
    build(i, w, a, wd, rd, er, lat);
    if (hold) begin
      repeat (lat) @(negedge clk);
    end else begin
      @(negedge clk);
      req[i] = 1'b0;
      repeat (lat - 1) @(negedge clk);
    end
  endtask

  task automatic preload(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_i  = i;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  int lat_unused;

  initial begin
    pl_en = 1'b0;
    pl_i  = 0;
    pl_a  = '0;
    pl_d  = '0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i]    = 1'b0;
      req[i]      = 1'b0;
      we[i]       = 1'b0;
      addr[i]     = '0;
      wdata[i]    = '0;
      force_rb[i] = 1'b0;
      last_rd[i]  = '0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_cs%0d", i), DW'(cs[i]), '0);
      chk($sformatf("rst_rw%0d", i), DW'(rw[i]), 1);
      chk($sformatf("rst_addr%0d", i), DW'(ba[i]), '0);
      chk($sformatf("rst_ack%0d", i), DW'(ack[i]), '0);
      chk($sformatf("rst_busy%0d", i), DW'(busy[i]), '0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], '0);
      chk($sformatf("rst_verr%0d", i), DW'(verr[i]), '0);
      chk($sformatf("rst_bus%0d", i), bus[i], KEEP);
    end
    preload(0, 12'h800, 32'h0800_0800);
    preload(1, 12'hFFF, 32'h0000_A5A5);
    @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Latency 1: write, read back, then back-to-back with req held.
    issue(0, 1'b1, 12'h123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(0, 1'b0, 12'h123, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(0, 1'b1, 12'h000, 32'h1111_1111, 32'h1111_1111, 1'b0, 1'b1);
    issue(0, 1'b0, 12'h800, '0, 32'h0800_0800, 1'b0, 1'b1);
    issue(0, 1'b1, 12'h800, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b1);
    issue(0, 1'b0, 12'h000, '0, 32'h1111_1111, 1'b0, 1'b0);
    issue(0, 1'b0, 12'h800, '0, 32'h2222_2222, 1'b0, 1'b0);

    // Latency 3: top address, then held write/read pair.
    issue(1, 1'b0, 12'hFFF, '0, 32'h0000_A5A5, 1'b0, 1'b0);
    issue(1, 1'b1, 12'h000, 32'h3333_3333, 32'h3333_3333, 1'b0, 1'b1);
    issue(1, 1'b0, 12'h000, '0, 32'h3333_3333, 1'b0, 1'b0);

    // Reset pulse during the second READ cycle abandons the transaction.
    @(negedge clk);
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 12'h010;
    build(1, 1'b0, 12'h010, '0, '0, 1'b0, lat_unused);
    @(negedge clk);
    req[1] = 1'b0;
    @(posedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_cs", DW'(cs[1]), '0);
    chk("midrst_bus", bus[1], KEEP);
    chk("midrst_busy", DW'(busy[1]), '0);
    chk("midrst_ack", DW'(ack[1]), '0);
    @(negedge clk);
    #1;
    rst_n[1]   = 1'b1;
    last_rd[1] = '0;
    repeat (4) @(negedge clk);
    issue(1, 1'b0, 12'hFFF, '0, 32'h0000_A5A5, 1'b0, 1'b0);

`ifdef RAM_BUS_MASTER_VERIFY_EN
    @(negedge clk);
    force_rb[0] = 1'b1;
    issue(0, 1'b1, 12'h020, 32'h1234_5678, FORCE, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    force_rb[0] = 1'b0;
    issue(0, 1'b1, 12'h020, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    issue(1, 1'b1, 12'h7FF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("q0_left", DW'(q0.size()), '0);
    chk("q1_left", DW'(q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
